fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch stage with a handshaked instruction-memory port,
//  an in-order prefetch queue and redirect/flush for branches and JAL/JALR.
//  Sits between the imem and decode; replaces the single-cycle PC register with a
//  decoupled stream of {instr, pc, pc+4} entries.
// PARAMETERS
//  XLEN      32  address/data width
//  DEPTH     4   prefetch queue entries; power of 2, >=2
//  MAX_OUT   2   max imem requests in flight; 1..DEPTH
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  redir_valid    in   1     redirect request, 1-cycle pulse from execute
//  redir_jalr     in   1     1: target=redir_base&~1; 0: target=redir_base+(redir_imm<<1)
//  redir_base     in   XLEN  branch PC, or ALU result for JALR
//  redir_imm      in   XLEN  immediate, halfword-scaled
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     imem accepts request
//  imem_req_addr  out  XLEN  fetch address, word aligned
//  imem_rsp_valid in   1     response valid; in order, >=1 cycle after accept
//  imem_rsp_data  in   32    instruction word
//  instr_valid    out  1     queue head valid
//  instr_ready    in   1     decode consumes head
//  instr_code     out  32    head instruction
//  instr_pc       out  XLEN  head PC
//  instr_pc4      out  XLEN  head PC+4
//  misalign_err   out  1     1-cycle pulse: redirect target had bit1 set
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC; queue empty; in-flight=0; stale=0; state=BOOT;
//   all outputs 0. The imem shares rst; pre-reset responses never arrive.
//  FSM: BOOT -> RUN after 1 cycle. RUN -> FLUSH on redirect if stale>0 after the
//   update, else stays RUN. FLUSH -> RUN when stale reaches 0. Redirect in FLUSH
//   reloads fetch_pc and stays in FLUSH.
//  Issue (RUN only): imem_req_valid=1 when count+in_flight<DEPTH and in_flight<MAX_OUT.
//   imem_req_addr=fetch_pc. On valid&ready, fetch_pc+=4 (mod 2^XLEN), in_flight++.
//  A raised request keeps valid and addr stable until accepted, even across a
//   redirect. If that request is accepted after the redirect, it is counted stale.
//  Response: if stale>0, drop it and decrement stale. Else push
//   {data, pc, pc+4} at the queue tail and decrement in_flight.
//   Space is guaranteed by the issue rule, so there is no overflow path.
//  Output: head is combinational from queue storage.
//   Pop on instr_valid&instr_ready. Push and pop in the same cycle are allowed.
//   A full queue with a pop accepts a push in the same cycle.
//  Redirect (highest priority), effective the next cycle:
//   - Compute the target.
//   - If target[1]=1: pulse misalign_err and force target[1:0]=0. Bit 0 is always
//     cleared.
//   - Set fetch_pc=target. Empty the queue; a same-cycle pop is discarded.
//   - Set stale=in_flight plus any response-side adjustment; set in_flight=0.
//   - A response arriving in the redirect cycle is dropped and is not counted in stale.
//   - instr_valid=0 in the cycle after the redirect.
//  Latency: the first request is one cycle after rst deasserts. With imem latency L,
//   instr_valid rises L+1 cycles after request accept (1 cycle for the push).
//   Redirect to first new request is 1 cycle when no stale responses exist.
//  Counters: in_flight and stale are clog2(MAX_OUT+1) bits and never wrap.
//   Queue pointers are clog2(DEPTH)+1 bits.
// TESTING
//  1. rst low 3 cycles, then high; imem always ready, L=1.
//     -> requests at 0,4,8,... and instr_pc sequence 0,4,8 with pc4 = pc+4.
//  2. instr_ready=0 with DEPTH=4.
//     -> exactly 4 entries are accepted, then req_valid stays 0 while responses are
//        pending; no overwrite.
//  3. Two requests in flight (L=3), then redirect jalr, base=0x105.
//     -> the 2 responses are dropped; the FLUSH state is visible; the next request
//        address is 0x104.
//  4. Redirect branch, base=0x40, imm=0x1.
//     -> target 0x42, misalign_err pulses once, next request address 0x40.
//  5. Redirect in the same cycle as a pop and a response.
//     -> the queue is empty next cycle, the response is dropped, and no stale
//        underflow occurs.
//  6. Assert rst mid-stream with a full queue.
//     -> all outputs are 0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: redirect input, imem request/response, decode-side instruction stream.
// Every valid/ready pair transfers on a rising clk edge where both are high. A raised valid
// holds its payload unchanged until that edge. A response has valid only; the fetch stage
// always has room for it.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redir_valid;
  logic            redir_jalr;
  logic [XLEN-1:0] redir_base;
  logic [XLEN-1:0] redir_imm;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_code;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc4;
  logic            misalign_err;

  // Fetch-stage side
  modport master (
    input  redir_valid, redir_jalr, redir_base, redir_imm,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_code, instr_pc, instr_pc4,
    input  instr_ready,
    output misalign_err
  );

  // Environment side (execute, imem, decode)
  modport slave (
    output redir_valid, redir_jalr, redir_base, redir_imm,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_code, instr_pc, instr_pc4,
    output instr_ready,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: issues word fetches to imem, queues in-order responses as
// {instr, pc, pc+4} entries, and handles redirects by flushing the queue and dropping
// responses that belong to the old stream (counted in stale_q).
// state_o exposes the FSM state: 0=BOOT, 1=RUN, 2=FLUSH.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_if.master      fq,
  output logic [1:0]         state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic            hold_q, hold_d;
  logic            hold_stale_q, hold_stale_d;
  logic            misalign_q, misalign_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]     code_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [PW:0]     count;
  logic [XLEN-1:0] target_raw, target;
  logic            issue_ok, req_valid, acc, push, pop;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign target_raw = fq.redir_jalr ? (fq.redir_base & ~XLEN'(1))
                                    : fq.redir_base + (fq.redir_imm << 1);
  assign target     = target_raw & ~XLEN'(3);
  assign acc        = req_valid & fq.imem_req_ready;
  assign push       = fq.imem_rsp_valid & (stale_q == '0) & ~fq.redir_valid;
  assign pop        = fq.instr_valid & fq.instr_ready & ~fq.redir_valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_BOOT;
    else      state_q <= state_d;
  end

  // FSM next state: a redirect with old-stream requests outstanding enters FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (fq.redir_valid && stale_d != '0) state_d = S_FLUSH;
      S_FLUSH: if (!fq.redir_valid && stale_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM outputs: request issue and the combinational queue head
  always_comb begin
    issue_ok          = (state_q == S_RUN) && (int'(count) + int'(in_flight_q) < DEPTH)
                        && (int'(in_flight_q) < MAX_OUT);
    req_valid         = hold_q | issue_ok;
    fq.imem_req_valid = req_valid;
    fq.imem_req_addr  = '0;
    if (req_valid) fq.imem_req_addr = hold_q ? hold_addr_q : fetch_pc_q;
    fq.instr_valid    = (count != '0);
    fq.instr_code     = '0;
    fq.instr_pc       = '0;
    fq.instr_pc4      = '0;
    if (count != '0) begin
      fq.instr_code = code_mem[rd_ptr_q[PW-1:0]];
      fq.instr_pc   = pc_mem[rd_ptr_q[PW-1:0]];
      fq.instr_pc4  = pc_mem[rd_ptr_q[PW-1:0]] + XLEN'(4);
    end
    fq.misalign_err   = misalign_q;
    state_o           = state_q;
  end

  // Datapath next state: redirect overrides issue, response and pop bookkeeping
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    in_flight_d  = in_flight_q;
    stale_d      = stale_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    misalign_d   = 1'b0;
    // A raised but unaccepted request is held with its address until accepted
    hold_d       = req_valid & ~fq.imem_req_ready;
    hold_addr_d  = fq.imem_req_addr;
    hold_stale_d = hold_stale_q & hold_d;
    if (fq.redir_valid) begin
      fetch_pc_d   = target;
      rsp_pc_d     = target;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      in_flight_d  = '0;
      misalign_d   = target_raw[1];
      // Everything old is stale, including a request raised now (accepted or held);
      // a response arriving now is dropped and so is not counted.
      stale_d      = stale_q + in_flight_q + CW'(req_valid & ~hold_stale_q)
                     - CW'(fq.imem_rsp_valid);
      hold_stale_d = hold_d;
    end else begin
      if (acc && !hold_stale_q) fetch_pc_d = fetch_pc_q + XLEN'(4);
      in_flight_d = in_flight_q + CW'(acc & ~hold_stale_q) - CW'(push);
      if (fq.imem_rsp_valid && stale_q != '0) stale_d = stale_q - CW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      hold_addr_q  <= '0;
      hold_q       <= 1'b0;
      hold_stale_q <= 1'b0;
      misalign_q   <= 1'b0;
      in_flight_q  <= '0;
      stale_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      hold_addr_q  <= hold_addr_d;
      hold_q       <= hold_d;
      hold_stale_q <= hold_stale_d;
      misalign_q   <= misalign_d;
      in_flight_q  <= in_flight_d;
      stale_q      <= stale_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Queue storage; entries are only visible while counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q[PW-1:0]] <= fq.imem_rsp_data;
      pc_mem[wr_ptr_q[PW-1:0]]   <= rsp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: behavioural imem with latency lat, decode-side consumer,
// and a scoreboard of {code, pc} entries expected in program order.
module tb_fetch_queue_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [1:0] ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) fq ();
  fetch_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .fq(fq), .state_o(state)
  );

  // Scoreboard and model state
  int n_checks = 0;
  int n_fail = 0;
  logic [63:0]     exp_q[$];
  logic [XLEN-1:0] mem_addr_q[$];
  int              mem_due_q[$];
  int              cyc = 0;
  int              lat = 1;
  int              pops = 0;
  logic [XLEN-1:0] next_exp = '0;
  logic [XLEN-1:0] post_addr = '0;
  bit              post_pending = 1'b1;
  bit              stale_hold = 1'b0;
  bit              exp_mis = 1'b0;
  bit              last_redir = 1'b0;
  bit              imem_rand = 1'b0;
  bit              dec_rand = 1'b0;
  bit              dec_ready = 1'b1;

  function automatic logic [31:0] code_of(input logic [XLEN-1:0] a);
    return {a[15:0] ^ 16'h5a5a, a[17:2]};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    next_exp     = '0;
    post_pending = 1'b1;
    stale_hold   = 1'b0;
    exp_mis      = 1'b0;
  endtask

  task automatic drive_idle();
    fq.redir_valid    = 1'b0;
    fq.redir_jalr     = 1'b0;
    fq.redir_base     = '0;
    fq.redir_imm      = '0;
    fq.imem_req_ready = 1'b0;
    fq.imem_rsp_valid = 1'b0;
    fq.imem_rsp_data  = '0;
    fq.instr_ready    = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, fq.imem_req_valid, 0);
    check({tag, "_req_addr"}, fq.imem_req_addr, 0);
    check({tag, "_instr_valid"}, fq.instr_valid, 0);
    check({tag, "_instr_code"}, fq.instr_code, 0);
    check({tag, "_instr_pc"}, fq.instr_pc, 0);
    check({tag, "_instr_pc4"}, fq.instr_pc4, 0);
    check({tag, "_misalign"}, fq.misalign_err, 0);
    check({tag, "_state"}, state, ST_BOOT);
  endtask

  // One clock of stimulus and checking, all done at the falling edge
  task automatic tick(input bit rv = 1'b0, input bit rj = 1'b0,
                      input logic [XLEN-1:0] rb = '0, input logic [XLEN-1:0] ri = '0,
                      input bit on_collide = 1'b0);
    logic [63:0]     e;
    logic [XLEN-1:0] t;
    bit              redir;
    @(negedge clk);
    cyc++;
    check("misalign_err", fq.misalign_err, exp_mis);
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      fq.imem_rsp_valid = 1'b1;
      fq.imem_rsp_data  = code_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      fq.imem_rsp_valid = 1'b0;
      fq.imem_rsp_data  = $urandom;
    end
    fq.imem_req_ready = imem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    fq.instr_ready    = dec_rand ? 1'($urandom_range(0, 1)) : dec_ready;
    redir = rv;
    if (on_collide && fq.imem_rsp_valid && fq.instr_valid && fq.instr_ready) redir = 1'b1;
    fq.redir_valid = redir;
    fq.redir_jalr  = rj;
    fq.redir_base  = rb;
    fq.redir_imm   = ri;
    #1;
    last_redir = redir;
    if (!redir && fq.instr_valid) begin
      if (exp_q.size() == 0) begin
        check("instr_valid_unexpected", fq.instr_valid, 0);
      end else if (fq.instr_ready) begin
        e = exp_q.pop_front();
        check("instr_pc", fq.instr_pc, e[31:0]);
        check("instr_code", fq.instr_code, e[63:32]);
        check("instr_pc4", fq.instr_pc4, e[31:0] + 32'd4);
        pops++;
      end
    end
    if (fq.imem_req_valid && fq.imem_req_ready) begin
      mem_addr_q.push_back(fq.imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      if (redir || stale_hold) begin
        stale_hold = 1'b0;
      end else begin
        check("req_addr", fq.imem_req_addr, next_exp);
        if (post_pending) begin
          post_addr    = fq.imem_req_addr;
          post_pending = 1'b0;
        end
        exp_q.push_back({code_of(next_exp), next_exp});
        next_exp = next_exp + 32'd4;
      end
    end else if (fq.imem_req_valid && redir) begin
      stale_hold = 1'b1;
    end
    exp_mis = 1'b0;
    if (redir) begin
      t = rj ? (rb & 32'hffff_fffe) : rb + (ri << 1);
      exp_mis = t[1];
      t[1:0] = 2'b00;
      exp_q.delete();
      next_exp     = t;
      post_pending = 1'b1;
    end
  endtask

  task automatic wait_post(input string tag, input logic [XLEN-1:0] exp);
    int n = 0;
    while (post_pending && n < 40) begin
      tick();
      n++;
    end
    if (post_pending) check({tag, "_timeout"}, post_pending, 1'b0);
    else              check(tag, post_addr, exp);
  endtask

  initial begin
    int  n;
    int  p0;
    bit  found;
    drive_idle();

    // Reset: outputs quiet, release, first request one cycle later at RESET_PC
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    #1;
    check("boot_no_req", fq.imem_req_valid, 0);
    tick();
    check("first_req_valid", fq.imem_req_valid, 1);
    check("first_req_addr", fq.imem_req_addr, 0);
    check("first_state", state, ST_RUN);

    // 1: streaming fetch, imem always ready, L=1
    repeat (20) tick();
    check("t1_stream_pops", pops >= 12, 1);

    // 2: decode stalled, queue fills to DEPTH and issue stops
    dec_ready = 1'b0;
    repeat (15) tick();
    check("t2_req_idle", fq.imem_req_valid, 0);
    check("t2_accepted", exp_q.size(), DEPTH);
    check("t2_imem_idle", mem_addr_q.size(), 0);
    check("t2_head_valid", fq.instr_valid, 1);
    dec_ready = 1'b1;
    repeat (10) tick();

    // 3: two requests in flight at L=3, then JALR redirect
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mem_addr_q.size() == 2) found = 1'b1;
    end
    check("t3_two_inflight", found, 1);
    tick(1'b1, 1'b1, 32'h105, 32'h0);
    tick();
    check("t3_flush_state", state, ST_FLUSH);
    check("t3_flush_empty", fq.instr_valid, 0);
    wait_post("t3_req_addr", 32'h104);
    repeat (10) tick();

    // 4: misaligned branch target
    lat = 1;
    repeat (5) tick();
    tick(1'b1, 1'b0, 32'h40, 32'h1);
    tick();
    check("t4_misalign_pulse", fq.misalign_err, 1);
    tick();
    check("t4_misalign_once", fq.misalign_err, 0);
    wait_post("t4_req_addr", 32'h40);
    repeat (5) tick();

    // 5: redirect coinciding with a pop and a response
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h200, 32'h10, 1'b1);
      found = last_redir;
    end
    check("t5_collision", found, 1);
    tick();
    check("t5_empty", fq.instr_valid, 0);
    p0 = pops;
    repeat (20) tick();
    check("t5_state_run", state, ST_RUN);
    check("t5_resumed", (pops - p0) >= 5, 1);

    // Random stress: random handshakes and redirects
    lat = 2;
    imem_rand = 1'b1;
    dec_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        tick(1'b1, 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 255)));
      else
        tick();
    end
    imem_rand = 1'b0;
    dec_rand = 1'b0;
    dec_ready = 1'b1;
    n = 0;
    while (state != ST_RUN && n < 40) begin
      tick();
      n++;
    end
    check("rand_back_to_run", state, ST_RUN);
    repeat (20) tick();

    // 6: asynchronous reset with a full queue, then restart at RESET_PC
    lat = 1;
    dec_ready = 1'b0;
    repeat (15) tick();
    check("t6_full_before", fq.instr_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    drive_idle();
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dec_ready = 1'b1;
    wait_post("t6_restart_addr", 32'h0);
    p0 = pops;
    repeat (20) tick();
    check("t6_stream_pops", (pops - p0) >= 12, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
